// File: rtl/arbiter_n2_pkg.sv
// Shared types and defaults for the 2-requester arbiter and its transfer stage.
package arbiter_n2_pkg;

  localparam int unsigned DEF_DW        = 32;
  localparam int unsigned DEF_MAX_BEATS = 16;
  localparam int unsigned DEF_CW        = 16;

  typedef logic [1:0] gnt_t;

  localparam gnt_t NO_GNT = 2'b00;
  localparam gnt_t GNT0   = 2'b01;
  localparam gnt_t GNT1   = 2'b10;

  typedef enum logic [1:0] {
    X_IDLE,
    X_S0,
    X_S1,
    X_DRAIN
  } xfer_state_t;

  function automatic gnt_t src_onehot(input logic src);
    return src ? GNT1 : GNT0;
  endfunction

endpackage

// File: rtl/arbiter_n2_out_reg.sv
// One-entry valid/ready output register carrying payload, last flag and source id.
module arbiter_n2_out_reg
  import arbiter_n2_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] in_data,
  input  logic          in_last,
  input  logic          in_src,
  output logic          in_ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          last,
  output logic          src,
  input  logic          ready
);

  // Accept a new beat when empty or when the held beat leaves this cycle.
  assign in_ready = !valid || ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      data  <= '0;
      last  <= 1'b0;
      src   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= in_data;
      last  <= in_last;
      src   <= in_src;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/arbiter_n2_xfer.sv
// Forwards the granted source's burst to a shared master port; pulses done per source.
// Optional burst counters are enabled by defining ARBITER_N2_XFER_PERF_EN.
module arbiter_n2_xfer
  import arbiter_n2_pkg::*;
#(
  parameter int unsigned DW        = DEF_DW,
  parameter int unsigned MAX_BEATS = DEF_MAX_BEATS,
  parameter int unsigned CW        = DEF_CW
) (
`ifdef ARBITER_N2_XFER_PERF_EN
  output logic [CW-1:0] burst_cnt0,
  output logic [CW-1:0] burst_cnt1,
`endif
  input  logic          clk,
  input  logic          rst,
  input  gnt_t          gnt,
  input  logic [DW-1:0] s0_data,
  input  logic          s0_valid,
  input  logic          s0_last,
  output logic          s0_ready,
  input  logic [DW-1:0] s1_data,
  input  logic          s1_valid,
  input  logic          s1_last,
  output logic          s1_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          m_last,
  output logic          m_src,
  input  logic          m_ready,
  output logic [1:0]    done,
  output logic          err
);

  localparam int unsigned BCW = $clog2(MAX_BEATS + 1);

  xfer_state_t    state;
  gnt_t           gnt_q;
  gnt_t           gnt_edge;
  logic [BCW-1:0] beat_cnt;

  logic           in_ready;
  logic           sel_valid;
  logic           sel_last;
  logic [DW-1:0]  sel_data;
  logic           accept;
  logic           overflow;
  logic           final_hs;

  assign gnt_edge = gnt & ~gnt_q;

  always_comb begin
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    case (state)
      X_S0: begin
        s0_ready  = in_ready;
        sel_valid = s0_valid;
        sel_last  = s0_last;
        sel_data  = s0_data;
      end
      X_S1: begin
        s1_ready  = in_ready;
        sel_valid = s1_valid;
        sel_last  = s1_last;
        sel_data  = s1_data;
      end
      default: ;
    endcase
  end

  assign accept   = sel_valid && in_ready && (state == X_S0 || state == X_S1);
  // The MAX_BEATS-th beat without last terminates the burst with a forced last.
  assign overflow = accept && !sel_last && (beat_cnt == BCW'(MAX_BEATS - 1));
  assign final_hs = (state == X_DRAIN) && m_valid && m_ready && m_last;
  assign done     = final_hs ? src_onehot(m_src) : NO_GNT;

  arbiter_n2_out_reg #(
    .DW(DW)
  ) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .in_data  (sel_data),
    .in_last  (sel_last || overflow),
    .in_src   (state == X_S1),
    .in_ready (in_ready),
    .valid    (m_valid),
    .data     (m_data),
    .last     (m_last),
    .src      (m_src),
    .ready    (m_ready)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= X_IDLE;
      gnt_q    <= NO_GNT;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else begin
      gnt_q <= gnt;
      if (gnt == 2'b11) begin
        err <= 1'b1;
      end
      case (state)
        X_IDLE: begin
          if (gnt_edge == 2'b11) begin
            err <= 1'b1;
          end else if (gnt_edge[0]) begin
            state <= X_S0;
          end else if (gnt_edge[1]) begin
            state <= X_S1;
          end
        end
        X_S0, X_S1: begin
          if (gnt_edge != NO_GNT) begin
            err <= 1'b1;
          end
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (sel_last || overflow) begin
              state <= X_DRAIN;
            end
          end
          if (overflow) begin
            err <= 1'b1;
          end
        end
        X_DRAIN: begin
          if (gnt_edge != NO_GNT) begin
            err <= 1'b1;
          end
          if (final_hs) begin
            beat_cnt <= '0;
            state    <= X_IDLE;
          end
        end
        default: state <= X_IDLE;
      endcase
    end
  end

`ifdef ARBITER_N2_XFER_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_cnt0 <= '0;
      burst_cnt1 <= '0;
    end else begin
      if (done[0] && burst_cnt0 != '1) begin
        burst_cnt0 <= burst_cnt0 + 1'b1;
      end
      if (done[1] && burst_cnt1 != '1) begin
        burst_cnt1 <= burst_cnt1 + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_arbiter_n2_xfer.sv
// Scoreboard bench for arbiter_n2_xfer: bursts are modelled per source, monitor checks outputs.
module tb_arbiter_n2_xfer;
  import arbiter_n2_pkg::*;

  localparam int DW = 32;
  localparam int MB = 4;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  gnt_t          gnt;
  logic [DW-1:0] s0_data, s1_data, m_data;
  logic          s0_valid, s0_last, s0_ready;
  logic          s1_valid, s1_last, s1_ready;
  logic          m_valid, m_last, m_src, m_ready;
  logic [1:0]    done;
  logic          err;
`ifdef ARBITER_N2_XFER_PERF_EN
  logic [CW-1:0] burst_cnt0, burst_cnt1;
`endif

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          src;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_checks  = 0;
  int    n_pass    = 0;
  int    rdy_mode  = 0;
  int    done_seen = 0;
  bit    exp_err   = 0;
  int    bursts0   = 0;
  int    bursts1   = 0;

  arbiter_n2_xfer #(
    .DW        (DW),
    .MAX_BEATS (MB),
    .CW        (CW)
  ) dut (
`ifdef ARBITER_N2_XFER_PERF_EN
    .burst_cnt0 (burst_cnt0),
    .burst_cnt1 (burst_cnt1),
`endif
    .clk      (clk),
    .rst      (rst),
    .gnt      (gnt),
    .s0_data  (s0_data),
    .s0_valid (s0_valid),
    .s0_last  (s0_last),
    .s0_ready (s0_ready),
    .s1_data  (s1_data),
    .s1_valid (s1_valid),
    .s1_last  (s1_last),
    .s1_ready (s1_ready),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_last   (m_last),
    .m_src    (m_src),
    .m_ready  (m_ready),
    .done     (done),
    .err      (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  task automatic drive(input bit src, input logic v, input logic [DW-1:0] dat, input logic l);
    if (src) begin
      s1_valid = v; s1_data = dat; s1_last = l;
    end else begin
      s0_valid = v; s0_data = dat; s0_last = l;
    end
  endtask

  // Downstream ready: 0 = always ready, 1 = random stalls, 2 = held by the main sequence.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) m_ready = 1'b1;
      else if (rdy_mode == 1) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          mon_e = exp_q[0];
          chk("m_data", m_data, mon_e.data);
          chk("m_last", m_last, mon_e.last);
          chk("m_src", m_src, mon_e.src);
          chk("done", done, (m_ready && mon_e.last) ? src_onehot(mon_e.src) : NO_GNT);
          if (m_ready) begin
            void'(exp_q.pop_front());
            if (mon_e.last) done_seen++;
          end else begin
            chk("s_ready_while_full", {s1_ready, s0_ready}, 2'b00);
          end
        end
      end else begin
        chk("done_idle", done, 2'b00);
      end
    end
  end

  // Model: a burst ends at the first real last, or is cut at MB beats with a forced last.
  task automatic send_burst(input bit src, input int len_in, input bit with_last,
                            input int inject, input bit hold);
    logic [DW-1:0] d[$];
    beat_t b;
    int len, n_acc, cyc, start_done;
    bit acc, ovf;
    len = len_in;
    if (!with_last && len <= MB) len = MB + 1;
    ovf   = !(with_last && len <= MB);
    n_acc = ovf ? MB : len;
    if (ovf) exp_err = 1;
    for (int k = 0; k < len; k++) d.push_back($urandom);
    for (int k = 0; k < n_acc; k++) begin
      b.data = d[k]; b.last = (k == n_acc - 1); b.src = src;
      exp_q.push_back(b);
    end
    start_done = done_seen;
    gnt = src_onehot(src);
    for (int k = 0; k < n_acc; k++) begin
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
      drive(src, 1'b1, d[k], with_last && (k == len - 1));
      acc = 0;
      cyc = 0;
      while (!acc && cyc < 100) begin
        @(negedge clk);
        acc = src ? s1_ready : s0_ready;
        cyc++;
        @(posedge clk);
        #1;
      end
      drive(src, 1'b0, '0, 1'b0);
      if (!acc) begin
        fail_now("beat_accept");
        break;
      end
      if (k == 0 && inject != 0) begin
        exp_err = 1;
        gnt = (inject == 1) ? gnt_t'(2'b11) : src_onehot(!src);
        @(posedge clk);
        #1;
        if (inject == 1) gnt = src_onehot(src);
      end
    end
    if (ovf) begin
      drive(src, 1'b1, d[n_acc], 1'b0);
      repeat (3) begin
        @(negedge clk);
        chk("ready_after_overflow", src ? s1_ready : s0_ready, 1'b0);
        @(posedge clk);
        #1;
      end
      drive(src, 1'b0, '0, 1'b0);
    end
    cyc = 0;
    while (done_seen == start_done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (done_seen == start_done) fail_now("done_wait");
    else if (src) bursts1++;
    else bursts0++;
    chk("err", err, exp_err);
    if (!hold) begin
      gnt = NO_GNT;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_perf();
`ifdef ARBITER_N2_XFER_PERF_EN
    chk("burst_cnt0", burst_cnt0, bursts0);
    chk("burst_cnt1", burst_cnt1, bursts1);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int cyc;
    beat_t b;
    rst = 1'b0;
    gnt = NO_GNT;
    m_ready = 1'b1;
    drive(0, 1'b0, '0, 1'b0);
    drive(1, 1'b0, '0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {m_valid, m_data, m_last, m_src, done, err, s0_ready, s1_ready}, '0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic src0 burst, gnt held afterwards: no second burst may start.
    send_burst(0, 3, 1, 0, 1);
    drive(0, 1'b1, 32'h1234_5678, 1'b0);
    repeat (4) begin
      @(negedge clk);
      chk("held_gnt_no_ready", s0_ready, 1'b0);
      chk("held_gnt_no_valid", m_valid, 1'b0);
      @(posedge clk);
      #1;
    end
    drive(0, 1'b0, '0, 1'b0);
    gnt = NO_GNT;
    @(posedge clk);
    #1;

    // src1 burst with a two-cycle downstream stall.
    fork
      send_burst(1, 4, 1, 0, 0);
      begin
        repeat (3) @(posedge clk);
        #1;
        rdy_mode = 2;
        m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rdy_mode = 0;
        m_ready = 1'b1;
      end
    join
    chk("err_clean", err, 1'b0);

    // Grant violations mid-burst: err set and sticky, bursts unaffected.
    send_burst(0, 3, 1, 1, 0);
    send_burst(1, 3, 1, 2, 0);
    send_burst(0, 2, 1, 0, 0);

    // Reset while a beat is held in the output register.
    rdy_mode = 2;
    m_ready = 1'b0;
    gnt = GNT0;
    b.data = 32'hdead_beef; b.last = 1'b0; b.src = 1'b0;
    exp_q.push_back(b);
    drive(0, 1'b1, 32'hdead_beef, 1'b0);
    acc = 0;
    cyc = 0;
    while (!acc && cyc < 20) begin
      @(negedge clk);
      acc = s0_ready;
      cyc++;
      @(posedge clk);
      #1;
    end
    drive(0, 1'b0, '0, 1'b0);
    if (!acc) fail_now("reset_test_accept");
    @(negedge clk);
    chk("m_valid_before_reset", m_valid, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", {m_valid, m_data, m_last, m_src, done, err, s0_ready, s1_ready},
        '0);
    exp_q.delete();
    gnt = NO_GNT;
    exp_err = 0;
    bursts0 = 0;
    bursts1 = 0;
    rdy_mode = 0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Overflow at MB beats, then normal bursts after reset.
    send_burst(0, 6, 0, 0, 0);
    send_burst(0, 2, 1, 0, 0);
    send_burst(1, 2, 1, 0, 0);
    check_perf();

    rdy_mode = 1;
    for (int i = 0; i < 20; i++) begin
      send_burst(1'($urandom_range(0, 1)), $urandom_range(1, 6), ($urandom_range(0, 3) != 0),
                 0, 0);
    end
    chk("queue_empty", exp_q.size(), 0);
    check_perf();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
